// File: rtl/pong_pkg.sv
// Shared types and default configuration for the tick-sampled button debouncer.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_PEND,
        ST_HELD,
        ST_RELEASE_PEND
    } deb_state_e;

    localparam int DEF_SAMPLES      = 4;
    localparam int DEF_REPEAT_DELAY = 16;
    localparam int DEF_REPEAT_RATE  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; clears on synchronous active-low Reset.
module sync_2ff (
    input  logic Clock,
    input  logic Reset,
    input  logic DataIn,
    output logic DataOut
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= DataIn;
            r_sync <= r_meta;
        end
    end

    assign DataOut = r_sync;

endmodule

// File: rtl/tick_debouncer.sv
// Tick-sampled button debouncer with Level/Press/Release outputs.
// Define TICK_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat Press pulses while held.
module tick_debouncer
    import pong_pkg::*;
#(
    parameter int SAMPLES      = DEF_SAMPLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Tick,
    input  logic ButtonIn,
    output logic Level,
    output logic Press,
    output logic Release
);

    localparam int             CNT_W    = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES - 1);

    logic             w_sync;
    deb_state_e       r_state;
    deb_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_press_next;
    logic             w_release_next;

`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
    localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

    // r_rep counts toward the first delay, then restarts for each repeat period.
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_next;
    logic [REP_W-1:0] w_rep_inc;
    logic             r_rep_run;
    logic             w_rep_run_next;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

    sync_2ff u_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .DataIn  (ButtonIn),
        .DataOut (w_sync)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
        w_rep_next     = r_rep;
        w_rep_run_next = r_rep_run;
        w_rep_inc      = r_rep + REP_W'(1);
`endif
        if (Tick) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_sync) begin
                        w_state_next = ST_PRESS_PEND;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
                ST_PRESS_PEND: begin
                    if (!w_sync) begin
                        w_state_next = ST_RELEASED;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                        w_press_next = 1'b1;
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
                        w_rep_next     = '0;
                        w_rep_run_next = 1'b0;
`endif
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!w_sync) begin
                        w_state_next = ST_RELEASE_PEND;
                        w_cnt_next   = CNT_W'(1);
                    end else begin
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
                        if (w_rep_inc == REP_W'(r_rep_run ? REPEAT_RATE : REPEAT_DELAY)) begin
                            w_press_next   = 1'b1;
                            w_rep_next     = '0;
                            w_rep_run_next = 1'b1;
                        end else begin
                            w_rep_next = w_rep_inc;
                        end
`endif
                    end
                end
                ST_RELEASE_PEND: begin
                    if (w_sync) begin
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next   = ST_RELEASED;
                        w_cnt_next     = '0;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_RELEASED;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= (w_state_next == ST_HELD) || (w_state_next == ST_RELEASE_PEND);
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_rep     <= '0;
            r_rep_run <= 1'b0;
        end else begin
            r_rep     <= w_rep_next;
            r_rep_run <= w_rep_run_next;
        end
    end
`endif

    assign Level   = r_level;
    assign Press   = r_press;
    assign Release = r_release;

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench for tick_debouncer: a reference model predicts pulses, a monitor checks them.
// Honours TICK_DEBOUNCER_AUTOREPEAT_EN the same way as the design.
module tb_tick_debouncer;

    localparam int SAMPLES      = 4;
    localparam int REPEAT_DELAY = 16;
    localparam int REPEAT_RATE  = 4;

    logic Clock = 1'b0;
    logic Reset;
    logic Tick;
    logic ButtonIn;
    logic Level;
    logic Press;
    logic Release;

    tick_debouncer #(
        .SAMPLES      (SAMPLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Tick     (Tick),
        .ButtonIn (ButtonIn),
        .Level    (Level),
        .Press    (Press),
        .Release  (Release)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit is_press;
        int cycle;
    } event_t;

    event_t q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     mon_en = 1'b0;

    // reference model state: accepted level, run of disagreeing tick samples, held-tick count
    bit m_q1, m_q2, m_level;
    int m_streak, m_rep;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit repeat_fires(input int held);
`ifdef TICK_DEBOUNCER_AUTOREPEAT_EN
        return (held == REPEAT_DELAY) ||
               (held > REPEAT_DELAY && ((held - REPEAT_DELAY) % REPEAT_RATE) == 0);
`else
        return (held < 0);
`endif
    endfunction

    // Model: the level flips once SAMPLES consecutive tick samples disagree with it.
    always @(posedge Clock) begin
        bit s;
        cyc++;
        if (!Reset) begin
            m_q1 = 0; m_q2 = 0; m_level = 0; m_streak = 0; m_rep = 0;
        end else begin
            s    = m_q2;
            m_q2 = m_q1;
            m_q1 = ButtonIn;
            if (Tick) begin
                if (s != m_level) begin
                    m_streak++;
                    if (m_streak == SAMPLES) begin
                        m_level  = s;
                        m_streak = 0;
                        q.push_back('{is_press: s, cycle: cyc});
                        if (s) m_rep = 0;
                    end
                end else begin
                    if (m_level && m_streak == 0) begin
                        m_rep++;
                        if (repeat_fires(m_rep)) q.push_back('{is_press: 1'b1, cycle: cyc});
                    end
                    m_streak = 0;
                end
            end
        end
    end

    // Monitor: checks Level every cycle and matches each output pulse to the scoreboard.
    always @(negedge Clock) begin
        if (mon_en) begin
            check("level", int'(Level), int'(m_level));
            while (q.size() > 0 && q[0].cycle < cyc) begin
                check("missed_pulse", 0, q[0].is_press ? 2 : 1);
                void'(q.pop_front());
            end
            if (Press || Release) begin
                if (q.size() == 0 || q[0].cycle != cyc) begin
                    check("unexpected_pulse", int'({Press, Release}), 0);
                end else begin
                    check("pulse_kind", int'({Press, Release}), q[0].is_press ? 2 : 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    int tick_mode = 1;  // 0 none, 1 every 8 clocks, 2 every clock, 3 random
    int phase     = 0;

    task automatic step(input logic b);
        @(negedge Clock);
        ButtonIn = b;
        case (tick_mode)
            0: Tick = 1'b0;
            1: begin
                Tick  = (phase == 0);
                phase = (phase + 1) % 8;
            end
            2: Tick = 1'b1;
            default: Tick = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic hold(input logic b, input int ticks);
        repeat (ticks * 8) step(b);
    endtask

    task automatic drain(input string name);
        @(negedge Clock);
        #1;
        check(name, q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic lvl_before;
        logic b;
        Reset = 1'b0; ButtonIn = 1'b1; Tick = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        check("reset_level", int'(Level), 0);
        check("reset_press", int'(Press), 0);
        check("reset_release", int'(Release), 0);
        Reset = 1'b0; ButtonIn = 1'b0; Tick = 1'b0;
        @(negedge Clock);
        Reset  = 1'b1;
        mon_en = 1'b1;

        // clean press then clean release
        hold(1'b1, 100);
        drain("clean_press");
        hold(1'b0, 10);
        drain("clean_release");

        // short press rejected
        hold(1'b1, 3);
        hold(1'b0, 10);
        drain("bounce_reject");
        check("bounce_level", int'(Level), 0);

        // release bounce, then real release
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 6);
        drain("release_bounce");

        // Tick idle while button toggles, mid release-pending
        hold(1'b1, 10);
        hold(1'b0, 2);
        @(negedge Clock);
        #1;
        lvl_before = Level;
        tick_mode = 0;
        repeat (200) step(1'(($urandom_range(0, 1))));
        #1;
        check("no_tick_level", int'(Level), int'(lvl_before));
        tick_mode = 1;
        hold(1'b0, 6);
        drain("no_tick_resume");

        // reset while in release-pending with the button still down
        hold(1'b1, 10);
        hold(1'b0, 2);
        @(negedge Clock);
        Reset = 1'b0; ButtonIn = 1'b1; Tick = 1'b1;
        @(negedge Clock);
        #1;
        check("midreset_level", int'(Level), 0);
        check("midreset_press", int'(Press), 0);
        check("midreset_release", int'(Release), 0);
        Reset = 1'b1;
        hold(1'b1, 8);
        drain("reset_repress");
        hold(1'b0, 8);

        // Tick held high every cycle with random runs
        tick_mode = 2;
        b = 1'b0;
        repeat (300) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            step(b);
        end
        drain("tick_always");

        // random Tick strobes and random button runs
        tick_mode = 3;
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) b = ~b;
            step(b);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_debouncer.md
TICK_DEBOUNCER -- requirements
Module: tick_debouncer

Interface
REQ-001 SHALL have parameter SAMPLES, default 4, consecutive agreeing Tick samples needed to change state (legal 2..255).
REQ-002 SHALL have parameter REPEAT_DELAY, default 16, Tick count from press to first auto-repeat Press (legal 1..255).
REQ-003 SHALL have parameter REPEAT_RATE, default 4, Tick count between later auto-repeat Press pulses (legal 1..255).
REQ-004 SHALL have port Clock  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port Tick  input  1  one-cycle sample strobe from the slow-clock enable generator.
REQ-007 SHALL have port ButtonIn  input  1  raw asynchronous button, active-high.
REQ-008 SHALL have port Level  output  1  debounced button state.
REQ-009 SHALL have port Press  output  1  one-cycle pulse per accepted press (and per auto-repeat).
REQ-010 SHALL have port Release  output  1  one-cycle pulse per accepted release.

Function
REQ-011 SHALL pass ButtonIn through a 2-flop synchronizer clocked every Clock cycle, not Tick-gated; synced value S.
REQ-012 SHALL implement FSM states RELEASED, PRESS_PEND, HELD, RELEASE_PEND; state, sample counter Cnt and repeat counter Rep change only on cycles with Tick=1.
REQ-013 RELEASED: Tick with S=1 -> PRESS_PEND, Cnt=1; S=0 -> stay.
REQ-014 PRESS_PEND: Tick with S=1 -> Cnt+1; on the Tick where Cnt+1 == SAMPLES -> HELD, Cnt=0; Tick with S=0 -> RELEASED, Cnt=0.
REQ-015 HELD: Tick with S=0 -> RELEASE_PEND, Cnt=1; S=1 -> stay.
REQ-016 RELEASE_PEND: Tick with S=0 -> Cnt+1; on Cnt+1 == SAMPLES -> RELEASED, Cnt=0; Tick with S=1 -> HELD, Cnt=0 (bounce rejected, no pulses).
REQ-017 Level SHALL be registered, 1 exactly while state is HELD or RELEASE_PEND.
REQ-018 Press SHALL assert for exactly one Clock cycle, the cycle after the Tick causing PRESS_PEND->HELD; Release likewise for RELEASE_PEND->RELEASED.
REQ-019 Latency: input change stable from a Tick onward is reported SAMPLES Ticks later plus 1 Clock (plus 2 Clock synchronizer).
REQ-020 Press and Release SHALL never assert in the same cycle; Tick held high continuously SHALL be treated as a Tick every cycle.
REQ-021 Counters SHALL saturate-free size to $clog2(max parameter+1) bits; no wrap possible within legal ranges.

Reset
REQ-022 Reset=0 at a rising Clock edge SHALL force state RELEASED, Cnt=0, Rep=0, synchronizer flops 0, Level=0, Press=0, Release=0, regardless of Tick or operation in progress.
REQ-023 Button held during reset release SHALL be reported only after SAMPLES Ticks per REQ-014.

Configuration
REQ-024 Macro TICK_DEBOUNCER_AUTOREPEAT_EN SHALL select auto-repeat.
REQ-025 Defined: Rep=0 on entry to HELD; each Tick in HELD increments Rep; Press pulses (1 cycle after that Tick) when Rep reaches REPEAT_DELAY, then every REPEAT_RATE Ticks; Rep holds during RELEASE_PEND and resumes on bounce back to HELD.
REQ-026 Not defined: no Rep counter in RTL; exactly one Press per accepted press; parameters REPEAT_DELAY/REPEAT_RATE unused.

Structure
REQ-027 Package pong_pkg SHALL hold the debounce state enum typedef and default constants for SAMPLES, REPEAT_DELAY, REPEAT_RATE.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (1-bit, Clock/Reset ports as above); FSM and counters stay in tick_debouncer.

Verification (SAMPLES=4, REPEAT_DELAY=16, REPEAT_RATE=4, Tick every 8 Clocks)
REQ-029 Clean press: ButtonIn 0->1 held 100 Ticks, macro off -> single Press 1 cycle after 4th sampling Tick of 1; Level=1 same cycle; no further Press.
REQ-030 Bounce reject: ButtonIn high for 3 Ticks then low -> Press, Level, Release stay 0; FSM back in RELEASED.
REQ-031 Release bounce: in HELD, ButtonIn low 2 Ticks then high -> Level stays 1, no Release; then low 4 Ticks -> one Release, Level=0.
REQ-032 Auto-repeat (macro on): hold 40 Ticks -> Press at Tick 4, then after HELD Ticks 16, 20, 24, 28, 32, 36 (7 total).
REQ-033 Reset mid-operation: Reset=0 one cycle while in RELEASE_PEND -> next cycle Level=0, Press=0, Release=0; with ButtonIn=1, Press reappears 4 Ticks (+sync) after reset deasserts.
REQ-034 No-Tick hold: Tick=0 for 200 cycles with ButtonIn toggling -> all outputs and state unchanged.
